// File: rtl/wb_master_ctrl_if.sv
// CPU request/response port plus Wishbone classic bus signals for wb_master_ctrl.
// The master modport is the controller's view; slave is the CPU/peripheral side.
interface wb_master_ctrl_if #(
  parameter int ADR_W = 16,
  parameter int DAT_W = 16,
  parameter int SEL_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [ADR_W-1:0] req_adr;
  logic [DAT_W-1:0] req_data;
  logic [SEL_W-1:0] req_sel;
  logic             rsp_valid;
  logic [DAT_W-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;
  logic [ADR_W-1:0] adr_out;
  logic [DAT_W-1:0] data_out;
  logic [DAT_W-1:0] data_in;
  logic             we;
  logic [SEL_W-1:0] sel_out;
  logic             stb_out;
  logic             cyc_out;
  logic             ack_in;
  logic             err_in;

  modport master (
    input  req_valid, req_we, req_adr, req_data, req_sel, data_in, ack_in, err_in,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy,
           adr_out, data_out, we, sel_out, stb_out, cyc_out
  );

  modport slave (
    output req_valid, req_we, req_adr, req_data, req_sel, data_in, ack_in, err_in,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
           adr_out, data_out, we, sel_out, stb_out, cyc_out
  );
endinterface

// File: rtl/wb_master_ctrl.sv
// Wishbone classic master: buffers CPU requests in a FIFO, runs one bus cycle
// per request and returns one in-order response with data and error flag.
module wb_master_ctrl #(
  parameter int ADR_W   = 16,
  parameter int DAT_W   = 16,
  parameter int SEL_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_master_ctrl_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ENT_W = 1 + ADR_W + DAT_W + SEL_W;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic               we_q, we_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               stb_q, stb_d;
  logic               cyc_q, cyc_d;

  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   head;
  logic               push, pop, done;

  assign push = bus.req_valid && req_ready_q;
  assign head = mem_q[rd_ptr_q];

  // Storage carries no reset; emptiness is defined purely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.req_we, bus.req_adr, bus.req_data, bus.req_sel};
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    stb_d       = stb_q;
    cyc_d       = cyc_q;
    pop         = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          we_d     = head[ENT_W-1];
          adr_d    = head[ENT_W-2 -: ADR_W];
          dat_d    = head[DAT_W+SEL_W-1 -: DAT_W];
          sel_d    = head[SEL_W-1:0];
          stb_d    = 1'b1;
          cyc_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = BUS;
        end
      end
      BUS: begin
        // err has priority over ack; timeout only when neither is seen
        if (bus.err_in) begin
          done       = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (bus.ack_in) begin
          done       = 1'b1;
          rsp_err_d  = 1'b0;
          rsp_data_d = we_q ? '0 : bus.data_in;
        end else if (to_cnt_q == TO_LAST) begin
          done       = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (done) begin
          stb_d       = 1'b0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          to_cnt_d    = '0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    req_ready_d = (count_d != FULL);
    busy_d      = (count_d != '0) || (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      to_cnt_q    <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      to_cnt_q    <= to_cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      stb_q       <= stb_d;
      cyc_q       <= cyc_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.adr_out   = adr_q;
  assign bus.data_out  = dat_q;
  assign bus.we        = we_q;
  assign bus.sel_out   = sel_q;
  assign bus.stb_out   = stb_q;
  assign bus.cyc_out   = cyc_q;
endmodule

// File: tb/tb_wb_master_ctrl.sv
// Scoreboard bench for wb_master_ctrl: a scripted/random Wishbone slave predicts
// each response from the request and its own reply choice; a monitor checks them.
module tb_wb_master_ctrl;
  localparam int TO = 8;

  typedef struct {logic we; logic [15:0] adr; logic [15:0] dat; logic [3:0] sel;} req_t;
  typedef struct {int mode; int delay; logic [15:0] rdata;} plan_t; // 0 ack,1 err,2 both,3 silent
  typedef struct {logic [15:0] dat; logic err;} rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_master_ctrl_if #(.ADR_W(16), .DAT_W(16), .SEL_W(4)) bus ();
  wb_master_ctrl #(.ADR_W(16), .DAT_W(16), .SEL_W(4), .DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  req_t  exp_req[$];
  rsp_t  exp_rsp[$];
  plan_t plan[$];
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_rsp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [3:0] s);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_we = w; bus.req_adr = a; bus.req_data = d; bus.req_sel = s;
    while (!bus.req_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!bus.req_ready) begin
      errors++;
      $display("FAIL req_accept_timeout actual=ready0 expected=ready1");
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_req.push_back('{w, a, d, s});
      n_acc++;
      #1 bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    logic ok = 1'b0;
    while (n < 2000 && !ok) begin
      @(posedge clk); #1; n++;
      ok = !bus.busy && exp_rsp.size() == 0 && !bus.rsp_valid;
    end
    chk("drain_done", ok, 1'b1);
  endtask

  // Wishbone slave: follows the plan queue, otherwise replies randomly.
  initial begin : slave
    logic  in_cyc;
    int    cnt, len, exp_len, m;
    plan_t p;
    req_t  r;
    in_cyc = 1'b0; cnt = 0; len = 0; exp_len = 0;
    p = '{0, 0, 16'h0}; r = '{1'b0, 16'h0, 16'h0, 4'h0};
    bus.ack_in = 1'b0; bus.err_in = 1'b0; bus.data_in = '0;
    forever begin
      @(posedge clk); #1;
      bus.ack_in = 1'b0; bus.err_in = 1'b0; bus.data_in = 16'($urandom);
      if (rst) begin
        in_cyc = 1'b0;
      end else if (bus.stb_out) begin
        if (!in_cyc) begin
          in_cyc = 1'b1; cnt = 0; len = 0;
          if (plan.size() != 0) p = plan.pop_front();
          else begin
            m = $urandom_range(0, 9);
            p.mode  = (m < 6) ? 0 : (m < 8) ? 1 : (m == 8) ? 2 : 3;
            p.delay = $urandom_range(0, 3);
            p.rdata = 16'($urandom);
          end
          checks++;
          if (exp_req.size() == 0) begin
            errors++;
            $display("FAIL stb_without_request actual=stb1 expected=stb0");
          end else r = exp_req.pop_front();
          exp_len = (p.mode == 3) ? TO : p.delay + 1;
          exp_rsp.push_back('{(p.mode == 0 && !r.we) ? p.rdata : 16'h0, p.mode != 0});
        end else cnt++;
        len++;
        chk("bus_cyc", bus.cyc_out, 1'b1);
        chk("bus_adr", bus.adr_out, r.adr);
        chk("bus_we", bus.we, r.we);
        chk("bus_sel", bus.sel_out, r.sel);
        if (r.we) chk("bus_wdata", bus.data_out, r.dat);
        if (p.mode != 3 && cnt == p.delay) begin
          bus.data_in = p.rdata;
          bus.ack_in  = (p.mode == 0 || p.mode == 2);
          bus.err_in  = (p.mode == 1 || p.mode == 2);
        end
      end else begin
        if (in_cyc) begin
          chk("stb_len", len, exp_len);
          chk("cyc_low", bus.cyc_out, 1'b0);
          in_cyc = 1'b0;
        end
        // stray ack/err outside a cycle must be ignored
        if ($urandom_range(0, 7) == 0) begin
          bus.ack_in = 1'b1;
          bus.err_in = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp actual=data %h err %0d expected=none", bus.rsp_data, bus.rsp_err);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", bus.rsp_data, e.dat);
          chk("rsp_err", bus.rsp_err, e.err);
        end
        n_rsp++;
        $display("rsp %0d data=%h err=%0d", n_rsp, bus.rsp_data, bus.rsp_err);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic seen;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_adr = '0; bus.req_data = '0; bus.req_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_stb", bus.stb_out, 1'b0);
    chk("rst_cyc", bus.cyc_out, 1'b0);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_adr", bus.adr_out, 16'h0);
    chk("rst_dout", bus.data_out, 16'h0);
    chk("rst_sel", bus.sel_out, 4'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 16'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);

    // single read with a delayed ack
    plan.push_back('{0, 2, 16'hBEEF});
    send(1'b0, 16'h0040, 16'h5555, 4'hF);
    chk("lat_stb_early", bus.stb_out, 1'b0);
    chk("lat_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    chk("lat_stb", bus.stb_out, 1'b1);
    chk("lat_cyc", bus.cyc_out, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        seen = 1'b1;
        chk("read_data", bus.rsp_data, 16'hBEEF);
        chk("read_cyc_low", bus.cyc_out, 1'b0);
      end
    end
    chk("read_rsp_seen", seen, 1'b1);
    @(posedge clk); #1;
    chk("rsp_pulse_one_cycle", bus.rsp_valid, 1'b0);
    wait_idle();

    // write acked in the first stb cycle
    plan.push_back('{0, 0, 16'hA5A5});
    send(1'b1, 16'h0010, 16'h1234, 4'hF);
    wait_idle();

    // fill the FIFO behind a stalled slave
    for (int i = 0; i < 6; i++) plan.push_back('{0, 3, 16'(16'h1000 + i)});
    for (int i = 0; i < 5; i++) send(i[0], 16'(16'h0100 + i), 16'(16'h2000 + i), 4'(i + 1));
    chk("full_ready_low", bus.req_ready, 1'b0);
    send(1'b0, 16'h0105, 16'h2005, 4'h6);
    wait_idle();

    // silent slave times out, next request still runs
    plan.push_back('{3, 0, 16'h0});
    plan.push_back('{0, 1, 16'hCAFE});
    send(1'b0, 16'h0200, 16'h0, 4'h3);
    send(1'b0, 16'h0204, 16'h0, 4'hC);
    wait_idle();

    // ack and err together
    plan.push_back('{2, 1, 16'h7777});
    send(1'b0, 16'h0300, 16'h0, 4'h1);
    wait_idle();

    // reset during a bus cycle with two requests queued
    for (int i = 0; i < 3; i++) plan.push_back('{3, 0, 16'h0});
    for (int i = 0; i < 3; i++) send(1'b1, 16'(16'h0400 + i), 16'h9999, 4'hF);
    chk("pre_rst_stb", bus.stb_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stb", bus.stb_out, 1'b0);
    chk("async_rst_cyc", bus.cyc_out, 1'b0);
    exp_req.delete(); exp_rsp.delete(); plan.delete();
    n_acc = 0; n_rsp = 0;
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_ready", bus.req_ready, 1'b1);
    chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("post_rst_idle", bus.busy, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_idle();

    chk("req_queue_empty", exp_req.size(), 0);
    chk("rsp_count", n_rsp, n_acc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
